// File: rtl/erx_dispatch_pkg.sv
// Shared eMesh packet layout, class and dispatch-state types for the eLink RX dispatcher.
package erx_pkg;

    localparam int unsigned PKT_W        = 104;
    localparam int unsigned ACCESS_BIT   = 0;
    localparam int unsigned WRITE_BIT    = 1;
    localparam int unsigned DATAMODE_LSB = 2;
    localparam int unsigned CTRLMODE_LSB = 4;
    localparam int unsigned DSTADDR_LSB  = 8;
    localparam int unsigned DATA_LSB     = 40;
    localparam int unsigned SRCADDR_LSB  = 72;

    typedef enum logic [1:0] {
        CLS_WR = 2'd0,
        CLS_RD = 2'd1,
        CLS_RR = 2'd2
    } cls_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BLOCKED = 2'd2
    } disp_state_e;

    function automatic logic [PKT_W-1:0] erx_pack(
        input logic        write,
        input logic [1:0]  datamode,
        input logic [3:0]  ctrlmode,
        input logic [31:0] dstaddr,
        input logic [31:0] data,
        input logic [31:0] srcaddr
    );
        return {srcaddr, data, dstaddr, ctrlmode, datamode, write, 1'b1};
    endfunction

endpackage

// File: rtl/erx_dispatch_if.sv
// Egress bundle of the RX dispatcher: write, read-request and read-response channels.
interface erx_dispatch_if;
    import erx_pkg::*;

    logic             wr_access;
    logic [PKT_W-1:0] wr_packet;
    logic             wr_wait;
    logic             rd_access;
    logic [PKT_W-1:0] rd_packet;
    logic             rd_wait;
    logic             rr_access;
    logic [PKT_W-1:0] rr_packet;
    logic             rr_wait;

    modport master (
        output wr_access, wr_packet, rd_access, rd_packet, rr_access, rr_packet,
        input  wr_wait, rd_wait, rr_wait
    );

    modport slave (
        input  wr_access, wr_packet, rd_access, rd_packet, rr_access, rr_packet,
        output wr_wait, rd_wait, rr_wait
    );

endinterface

// File: rtl/erx_dispatch_fifo.sv
// Skid FIFO for decoded eMesh packets; the caller guarantees no write when full unless reading.
module erx_dispatch_fifo
    import erx_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             rx_lclk_div4,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [PKT_W-1:0] din,
    output logic [PKT_W-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge rx_lclk_div4 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: discarded entries are invalidated by the pointers alone.
    always_ff @(posedge rx_lclk_div4) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/erx_dispatch.sv
// eLink RX dispatcher: buffers decoded eMesh packets and issues them in order to wr/rd/rr channels.
// Optional build macro ERX_DISPATCH_STATS_EN adds saturating issue/blocked statistics outputs.
module erx_dispatch
    import erx_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_MARGIN = 4,
    parameter int unsigned ID_W        = 12
) (
    input  logic            rx_lclk_div4,
    input  logic            reset,
    input  logic            emesh_rx_access,
    input  logic            emesh_rx_write,
    input  logic [1:0]      emesh_rx_datamode,
    input  logic [3:0]      emesh_rx_ctrlmode,
    input  logic [31:0]     emesh_rx_dstaddr,
    input  logic [31:0]     emesh_rx_srcaddr,
    input  logic [31:0]     emesh_rx_data,
    output logic            emesh_rx_wr_wait,
    output logic            emesh_rx_rd_wait,
    input  logic [ID_W-1:0] cfg_id,
    erx_dispatch_if.master  egress,
`ifdef ERX_DISPATCH_STATS_EN
    output logic [15:0]     stat_wr,
    output logic [15:0]     stat_rd,
    output logic [15:0]     stat_rr,
    output logic [15:0]     stat_blk,
`endif
    output logic            ovf_err
);

    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [AW:0] ONE         = (AW+1)'(1);
    localparam logic [AW:0] WAIT_THRESH = (AW+1)'(DEPTH - WAIT_MARGIN);

    logic [PKT_W-1:0] head;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             full;
    logic             empty;
    logic             issue;
    logic             enq;
    logic             drop;
    logic             head_wait;
    cls_e             head_cls;
    disp_state_e      state;

    erx_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .rx_lclk_div4 (rx_lclk_div4),
        .reset        (reset),
        .wr_en        (enq),
        .rd_en        (issue),
        .din          (erx_pack(emesh_rx_write, emesh_rx_datamode, emesh_rx_ctrlmode,
                                emesh_rx_dstaddr, emesh_rx_data, emesh_rx_srcaddr)),
        .dout         (head),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Dispatch state is derived from occupancy and the head's channel wait, not stored.
    always_comb begin
        head_cls  = CLS_WR;
        head_wait = 1'b0;
        state     = ST_ISSUE;
        if (!head[WRITE_BIT])
            head_cls = CLS_RD;
        else if (head[DSTADDR_LSB+31 -: ID_W] == cfg_id)
            head_cls = CLS_RR;
        case (head_cls)
            CLS_RD:  head_wait = egress.rd_wait;
            CLS_RR:  head_wait = egress.rr_wait;
            default: head_wait = egress.wr_wait;
        endcase
        if (empty)
            state = ST_EMPTY;
        else if (head_wait)
            state = ST_BLOCKED;
    end

    // An issue on the same edge frees a slot, so a full FIFO still accepts.
    always_comb begin
        issue      = (state == ST_ISSUE);
        enq        = emesh_rx_access && (!full || issue);
        drop       = emesh_rx_access && full && !issue;
        count_next = count;
        if (enq && !issue)
            count_next = count + ONE;
        else if (!enq && issue)
            count_next = count - ONE;
    end

    always_ff @(posedge rx_lclk_div4 or posedge reset) begin
        if (reset) begin
            egress.wr_access <= 1'b0;
            egress.rd_access <= 1'b0;
            egress.rr_access <= 1'b0;
            egress.wr_packet <= '0;
            egress.rd_packet <= '0;
            egress.rr_packet <= '0;
            emesh_rx_wr_wait <= 1'b0;
            emesh_rx_rd_wait <= 1'b0;
            ovf_err          <= 1'b0;
        end else begin
            egress.wr_access <= issue && (head_cls == CLS_WR);
            egress.rd_access <= issue && (head_cls == CLS_RD);
            egress.rr_access <= issue && (head_cls == CLS_RR);
            if (issue && head_cls == CLS_WR) egress.wr_packet <= head;
            if (issue && head_cls == CLS_RD) egress.rd_packet <= head;
            if (issue && head_cls == CLS_RR) egress.rr_packet <= head;
            emesh_rx_wr_wait <= (count_next >= WAIT_THRESH);
            emesh_rx_rd_wait <= (count_next >= WAIT_THRESH);
            ovf_err          <= ovf_err | drop;
        end
    end

`ifdef ERX_DISPATCH_STATS_EN
    always_ff @(posedge rx_lclk_div4 or posedge reset) begin
        if (reset) begin
            stat_wr  <= '0;
            stat_rd  <= '0;
            stat_rr  <= '0;
            stat_blk <= '0;
        end else begin
            if (issue && head_cls == CLS_WR && stat_wr != '1) stat_wr <= stat_wr + 16'd1;
            if (issue && head_cls == CLS_RD && stat_rd != '1) stat_rd <= stat_rd + 16'd1;
            if (issue && head_cls == CLS_RR && stat_rr != '1) stat_rr <= stat_rr + 16'd1;
            if (state == ST_BLOCKED && stat_blk != '1)        stat_blk <= stat_blk + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_erx_dispatch.sv
// Scoreboard bench for erx_dispatch: queue-level reference model, directed scenarios and random traffic.
module tb_erx_dispatch;
    import erx_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WM    = 4;
    localparam int unsigned ID_W  = 12;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            acc = 1'b0;
    logic            wr = 1'b0;
    logic [1:0]      dm = '0;
    logic [3:0]      cm = '0;
    logic [31:0]     dst = '0;
    logic [31:0]     src = '0;
    logic [31:0]     dat = '0;
    logic            e_wr_wait;
    logic            e_rd_wait;
    logic [ID_W-1:0] cfg_id = 12'h808;
    logic            ovf;

    erx_dispatch_if eg ();

`ifdef ERX_DISPATCH_STATS_EN
    logic [15:0] stat_wr, stat_rd, stat_rr, stat_blk;
    int unsigned m_wr, m_rd, m_rr, m_blk;
`endif

    always #5 clk = ~clk;

    erx_dispatch #(.DEPTH(DEPTH), .WAIT_MARGIN(WM), .ID_W(ID_W)) dut (
        .rx_lclk_div4      (clk),
        .reset             (reset),
        .emesh_rx_access   (acc),
        .emesh_rx_write    (wr),
        .emesh_rx_datamode (dm),
        .emesh_rx_ctrlmode (cm),
        .emesh_rx_dstaddr  (dst),
        .emesh_rx_srcaddr  (src),
        .emesh_rx_data     (dat),
        .emesh_rx_wr_wait  (e_wr_wait),
        .emesh_rx_rd_wait  (e_rd_wait),
        .cfg_id            (cfg_id),
        .egress            (eg.master),
`ifdef ERX_DISPATCH_STATS_EN
        .stat_wr           (stat_wr),
        .stat_rd           (stat_rd),
        .stat_rr           (stat_rr),
        .stat_blk          (stat_blk),
`endif
        .ovf_err           (ovf)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    logic [PKT_W-1:0] mfifo[$];
    logic [PKT_W-1:0] expq[$];
    bit exp_iss = 0;
    bit exp_wait = 0;
    bit exp_ovf = 0;

    task automatic chk(input string nm, input logic [PKT_W-1:0] a, input logic [PKT_W-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic cls_e classify(input logic [PKT_W-1:0] p);
        if (!p[1]) return CLS_RD;
        if (p[39:28] == cfg_id) return CLS_RR;
        return CLS_WR;
    endfunction

    function automatic bit wait_of(input cls_e c);
        if (c == CLS_RD) return eg.rd_wait;
        if (c == CLS_RR) return eg.rr_wait;
        return eg.wr_wait;
    endfunction

    // Reference model: in-order queue of held packets, evaluated at each clock edge.
    always @(posedge clk) begin
        int unsigned sz0;
        bit iss;
        logic [PKT_W-1:0] p;
        if (reset) begin
            mfifo.delete();
            expq.delete();
            exp_iss = 0; exp_wait = 0; exp_ovf = 0;
`ifdef ERX_DISPATCH_STATS_EN
            m_wr = 0; m_rd = 0; m_rr = 0; m_blk = 0;
`endif
        end else begin
            sz0 = mfifo.size();
            iss = 0;
            if (sz0 > 0) iss = !wait_of(classify(mfifo[0]));
`ifdef ERX_DISPATCH_STATS_EN
            if (sz0 > 0 && !iss) m_blk++;
            if (iss) begin
                case (classify(mfifo[0]))
                    CLS_RD:  m_rd++;
                    CLS_RR:  m_rr++;
                    default: m_wr++;
                endcase
            end
`endif
            if (iss) void'(mfifo.pop_front());
            if (acc) begin
                p = {src, dat, dst, cm, dm, wr, 1'b1};
                if (sz0 < DEPTH || iss) begin
                    mfifo.push_back(p);
                    expq.push_back(p);
                end else begin
                    exp_ovf = 1;
                end
            end
            exp_wait = (mfifo.size() >= DEPTH - WM);
            exp_iss  = iss;
        end
    end

    // Monitor: compares DUT egress and status against the model away from the active edge.
    always @(negedge clk) begin
        int n;
        logic [PKT_W-1:0] e, got;
        cls_e gc;
        if (!reset) begin
            n = int'(eg.wr_access) + int'(eg.rd_access) + int'(eg.rr_access);
            chk("issue_pulse", PKT_W'(n), PKT_W'(exp_iss ? 1 : 0));
            if (n == 1) begin
                if (expq.size() == 0) begin
                    chk("issue_unexpected", PKT_W'(1), PKT_W'(0));
                end else begin
                    e = expq.pop_front();
                    gc = eg.rd_access ? CLS_RD : (eg.rr_access ? CLS_RR : CLS_WR);
                    got = eg.rd_access ? eg.rd_packet : (eg.rr_access ? eg.rr_packet : eg.wr_packet);
                    chk("issue_chan", PKT_W'(gc), PKT_W'(classify(e)));
                    chk("issue_pkt", got, e);
                end
            end
            chk("wr_wait_out", PKT_W'(e_wr_wait), PKT_W'(exp_wait));
            chk("rd_wait_out", PKT_W'(e_rd_wait), PKT_W'(exp_wait));
            chk("ovf_err", PKT_W'(ovf), PKT_W'(exp_ovf));
        end
    end

    task automatic put(input logic w, input logic [31:0] d);
        @(negedge clk);
        acc = 1'b1; wr = w; dst = d;
        dat = $urandom; src = $urandom; dm = 2'($urandom); cm = 4'($urandom);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            acc = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned k = 0;
        eg.wr_wait = 0; eg.rd_wait = 0; eg.rr_wait = 0;
        while ((expq.size() != 0 || mfifo.size() != 0) && k < 200) begin
            idle(1);
            k++;
        end
        idle(3);
        chk("drain_timeout", PKT_W'(expq.size()), PKT_W'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        acc = 1'b0; reset = 1'b1;
        #1;
        chk("rst_access", PKT_W'({eg.wr_access, eg.rd_access, eg.rr_access}), PKT_W'(0));
        chk("rst_wait", PKT_W'({e_wr_wait, e_rd_wait}), PKT_W'(0));
        chk("rst_ovf", PKT_W'(ovf), PKT_W'(0));
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        eg.wr_wait = 0; eg.rd_wait = 0; eg.rr_wait = 0;
        #1;
        chk("rst_packets", eg.wr_packet | eg.rd_packet | eg.rr_packet, '0);
        idle(2);
        reset = 1'b0;

        // 1: write to own chip ID becomes a read response, two cycles later
        put(1'b1, 32'h8080_0000);
        @(negedge clk); acc = 1'b0;
        chk("t1_no_early", PKT_W'(eg.rr_access), PKT_W'(0));
        @(negedge clk);
        chk("t1_rr_access", PKT_W'(eg.rr_access), PKT_W'(1));
        chk("t1_rr_dst", PKT_W'(eg.rr_packet[39:8]), PKT_W'(32'h8080_0000));
        chk("t1_others", PKT_W'({eg.wr_access, eg.rd_access}), PKT_W'(0));
        idle(3);

        // 2: read then foreign write back-to-back
        put(1'b0, 32'h1234_5678);
        put(1'b1, 32'h8100_0000);
        idle(5);

        // 3: read channel blocked, overflow on the ninth packet
        eg.rd_wait = 1;
        for (int i = 0; i < 8; i++) put(1'b0, $urandom);
        put(1'b1, 32'h8100_0000);
        idle(3);
        chk("t3_ovf_set", PKT_W'(ovf), PKT_W'(1));
        eg.rd_wait = 0;
        idle(12);
        chk("t3_ovf_sticky", PKT_W'(ovf), PKT_W'(1));

        // 4: full FIFO, enqueue on the same edge as an issue
        do_reset();
        eg.rd_wait = 1;
        for (int i = 0; i < 8; i++) put(1'b0, $urandom);
        put(1'b0, 32'hDEAD_0000);
        eg.rd_wait = 0;
        idle(1);
        chk("t4_no_ovf", PKT_W'(ovf), PKT_W'(0));
        chk("t4_wait_held", PKT_W'(e_rd_wait), PKT_W'(1));
        drain();

        // 5: blocked write at head holds back a read behind it
        eg.wr_wait = 1;
        put(1'b1, 32'h8100_0000);
        put(1'b0, 32'h0000_1000);
        idle(4);
        chk("t5_hol", PKT_W'(eg.rd_access), PKT_W'(0));
        eg.wr_wait = 0;
        idle(5);

        // 6: reset with five packets held
        eg.wr_wait = 1;
        for (int i = 0; i < 5; i++) put(1'b1, 32'h8100_0000);
        idle(2);
        do_reset();
        eg.wr_wait = 0;
        idle(10);

        // random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            acc = ($urandom_range(0, 9) < 6);
            wr = $urandom_range(0, 1);
            dst = $urandom;
            if ($urandom_range(0, 2) == 0) dst[31:20] = cfg_id;
            dat = $urandom; src = $urandom; dm = 2'($urandom); cm = 4'($urandom);
            eg.wr_wait = ($urandom_range(0, 9) < 3);
            eg.rd_wait = ($urandom_range(0, 9) < 3);
            eg.rr_wait = ($urandom_range(0, 9) < 3);
        end
        acc = 1'b0;
        drain();

`ifdef ERX_DISPATCH_STATS_EN
        chk("stat_wr", PKT_W'(stat_wr), PKT_W'(m_wr));
        chk("stat_rd", PKT_W'(stat_rd), PKT_W'(m_rd));
        chk("stat_rr", PKT_W'(stat_rr), PKT_W'(m_rr));
        chk("stat_blk", PKT_W'(stat_blk), PKT_W'(m_blk));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
